// File: rtl/ldst_seq_pkg.sv
// Shared constants, types and helpers for the load/store issue sequencer.
package ldst_seq_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned LANES = 4;

  localparam logic [OP_W-1:0] OP_LOAD  = 4'b0010;
  localparam logic [OP_W-1:0] OP_STORE = 4'b0100;

  typedef logic [LANES-1:0] lane_mask_t;

  typedef enum logic [1:0] {
    IDLE,
    FORM,
    OFFER
  } state_t;

  // Only the exact load/store encodings use the memory port.
  function automatic logic is_mem(input logic [OP_W-1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/ldst_issue_sequencer_mem_group_former.sv
// Combinational group former: takes the longest in-order run of pending lanes
// holding at most one mem op, cut short before a mem op while the memory unit is busy.
module mem_group_former
  import ldst_seq_pkg::*;
(
  input  lane_mask_t              i_pending,
  input  logic [LANES*OP_W-1:0]   i_ops,
  input  logic                    i_mem_busy,
  output lane_mask_t              o_mask,
  output logic                    o_mem,
  output logic                    o_empty
);

  lane_mask_t w_mask;
  logic       w_mem;
  logic       w_open;
  logic       w_done;

  always_comb begin
    w_mask = '0;
    w_mem  = 1'b0;
    w_open = 1'b0;
    w_done = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!w_done) begin
        if (i_pending[i]) begin
          if (is_mem(i_ops[i*OP_W +: OP_W])) begin
            if (w_mem || i_mem_busy) begin
              w_done = 1'b1;
            end else begin
              w_mask[i] = 1'b1;
              w_mem     = 1'b1;
              w_open    = 1'b1;
            end
          end else begin
            w_mask[i] = 1'b1;
            w_open    = 1'b1;
          end
        end else if (w_open) begin
          w_done = 1'b1;
        end
      end
    end
  end

  assign o_mask  = w_mask;
  assign o_mem   = w_mem;
  assign o_empty = (w_mask == '0);

endmodule

// File: rtl/ldst_issue_sequencer.sv
// Splits a 4-lane bundle into in-order issue groups with at most one load/store each.
// Optional macro LDST_SEQ_BACK_TO_BACK_EN: accept the next bundle on the final handshake.
module ldst_issue_sequencer
  import ldst_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bundle_valid,
  output logic                  bundle_ready,
  input  logic [4*OP_W-1:0]     bundle_op,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [3:0]            issue_mask,
  output logic                  issue_mem,
  input  logic                  mem_busy,
  output logic                  busy
);

  state_t               r_state;
  logic [4*OP_W-1:0]    r_ops;
  lane_mask_t           r_pending;
  lane_mask_t           r_mask;
  logic                 r_mem;
  logic                 r_valid;

  lane_mask_t           w_grp_mask;
  logic                 w_grp_mem;
  logic                 w_grp_empty;
  lane_mask_t           w_remaining;
  logic                 w_bundle_ready;
  logic                 w_accept;

  mem_group_former u_former (
    .i_pending  (r_pending),
    .i_ops      (r_ops),
    .i_mem_busy (mem_busy),
    .o_mask     (w_grp_mask),
    .o_mem      (w_grp_mem),
    .o_empty    (w_grp_empty)
  );

  assign w_remaining = r_pending & ~r_mask;

  always_comb begin
    w_bundle_ready = (r_state == IDLE);
`ifdef LDST_SEQ_BACK_TO_BACK_EN
    // Gated by issue_ready: the new bundle may only replace one whose last group leaves now.
    if ((r_state == OFFER) && (w_remaining == '0) && issue_ready)
      w_bundle_ready = 1'b1;
`endif
  end

  assign w_accept = bundle_valid && w_bundle_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ops     <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_mem     <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ops     <= bundle_op;
            r_pending <= '1;
            r_state   <= FORM;
          end
        end
        FORM: begin
          if (!w_grp_empty) begin
            r_mask  <= w_grp_mask;
            r_mem   <= w_grp_mem;
            r_valid <= 1'b1;
            r_state <= OFFER;
          end
        end
        OFFER: begin
          if (issue_ready) begin
            r_pending <= w_remaining;
            r_mask    <= '0;
            r_mem     <= 1'b0;
            r_valid   <= 1'b0;
            if (w_accept) begin
              r_ops     <= bundle_op;
              r_pending <= '1;
              r_state   <= FORM;
            end else if (w_remaining == '0) begin
              r_state <= IDLE;
            end else begin
              r_state <= FORM;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bundle_ready = w_bundle_ready;
  assign issue_valid  = r_valid;
  assign issue_mask   = r_mask;
  assign issue_mem    = r_mem;
  assign busy         = (r_pending != '0);

endmodule

// File: tb/tb_ldst_issue_sequencer.sv
// Scoreboard bench: stimulus pushes expected issue groups, a monitor pops on each handshake.
module tb_ldst_issue_sequencer;

  localparam logic [3:0] LD  = 4'b0010;
  localparam logic [3:0] ST  = 4'b0100;
  localparam logic [3:0] ALU = 4'b0001;

  typedef struct packed {
    logic [3:0] mask;
    logic       mem;
  } grp_t;

  logic        clk;
  logic        rst_n;
  logic        bundle_valid;
  logic        bundle_ready;
  logic [15:0] bundle_op;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_mask;
  logic        issue_mem;
  logic        mem_busy;
  logic        busy;

  grp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  ldst_issue_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bundle_valid (bundle_valid),
    .bundle_ready (bundle_ready),
    .bundle_op    (bundle_op),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_mask   (issue_mask),
    .issue_mem    (issue_mem),
    .mem_busy     (mem_busy),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, required event", name);
  endtask

  // Reference: cut the bundle in order, opening a new group whenever a second mem op appears.
  function automatic void model_push(input logic [15:0] ops);
    grp_t       g;
    logic [3:0] op;
    logic       m;
    g = '0;
    for (int i = 0; i < 4; i++) begin
      op = ops[i*4 +: 4];
      m  = (op == LD) || (op == ST);
      if (m && g.mem) begin
        exp_q.push_back(g);
        g = '0;
      end
      g.mask[i] = 1'b1;
      if (m) g.mem = 1'b1;
    end
    exp_q.push_back(g);
  endfunction

  function automatic void push_grp(input logic [3:0] mask, input logic mem);
    grp_t g;
    g.mask = mask;
    g.mem  = mem;
    exp_q.push_back(g);
  endfunction

  initial begin
    grp_t g;
    forever begin
      @(negedge clk);
      if (rst_n && issue_valid && issue_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_group: got mask=%b mem=%b, required no group", issue_mask, issue_mem);
        end else begin
          g = exp_q.pop_front();
          if (issue_mask !== g.mask || issue_mem !== g.mem) begin
            errors++;
            $display("FAIL group: got mask=%b mem=%b, required mask=%b mem=%b",
                     issue_mask, issue_mem, g.mask, g.mem);
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] ops, input bit use_model);
    int n;
    n = 0;
    @(negedge clk);
    while (!bundle_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bundle_ready) fail_timeout("bundle_accept");
    if (use_model) model_push(ops);
    bundle_valid = 1'b1;
    bundle_op    = ops;
    @(posedge clk);
    #1 bundle_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail_timeout(name);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    chk({name, "_busy_done"}, {3'b0, busy}, 4'd0);
    chk({name, "_ready_done"}, {3'b0, bundle_ready}, 4'd1);
    chk({name, "_valid_done"}, {3'b0, issue_valid}, 4'd0);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!issue_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!issue_valid) fail_timeout(name);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_valid"}, {3'b0, issue_valid}, 4'd0);
    chk({name, "_mask"}, issue_mask, 4'b0000);
    chk({name, "_mem"}, {3'b0, issue_mem}, 4'd0);
    chk({name, "_busy"}, {3'b0, busy}, 4'd0);
    chk({name, "_bready"}, {3'b0, bundle_ready}, 4'd1);
  endtask

  initial begin
    int          sent;
    int          cyc;
    logic [15:0] rops;
    logic [3:0]  rop;

    rst_n        = 1'b0;
    bundle_valid = 1'b0;
    bundle_op    = '0;
    issue_ready  = 1'b0;
    mem_busy     = 1'b0;
    #1 chk_reset_vals("in_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("after_reset");

    // 1: LOAD,ALU,STORE,ALU -> 0011 then 1100, both mem
    issue_ready = 1'b1;
    send({ALU, ST, ALU, LD}, 1'b1);
    drain("t1");

    // 2: all ALU -> one group, first valid two cycles after accept
    send({4'b0110, 4'b0101, 4'b0011, 4'b0001}, 1'b1);
    @(negedge clk);
    chk("t2_valid_n1", {3'b0, issue_valid}, 4'd0);
    chk("t2_bready_form", {3'b0, bundle_ready}, 4'd0);
    @(negedge clk);
    chk("t2_valid_n2", {3'b0, issue_valid}, 4'd1);
    drain("t2");

    // 3: all mem -> four single-lane groups
    send({ST, LD, ST, LD}, 1'b1);
    drain("t3");

    // 4: memory busy truncates the first group and then stalls FORM
    mem_busy = 1'b1;
    push_grp(4'b0001, 1'b0);
    push_grp(4'b1110, 1'b1);
    send({ALU, ALU, LD, ALU}, 1'b0);
    cyc = 0;
    while (exp_q.size() != 1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() != 1) fail_timeout("t4_first_group");
    repeat (3) begin
      @(negedge clk);
      chk("t4_stall_valid", {3'b0, issue_valid}, 4'd0);
      chk("t4_stall_busy", {3'b0, busy}, 4'd1);
    end
    @(posedge clk);
    #1 mem_busy = 1'b0;
    drain("t4");

    // 5: offer held stable under back-pressure with mem_busy toggling
    issue_ready = 1'b0;
    send({ALU, ST, ALU, LD}, 1'b1);
    wait_valid("t5_valid");
    repeat (3) begin
      @(posedge clk);
      #1 mem_busy = ~mem_busy;
      @(negedge clk);
      chk("t5_hold_valid", {3'b0, issue_valid}, 4'd1);
      chk("t5_hold_mask", issue_mask, 4'b0011);
      chk("t5_hold_mem", {3'b0, issue_mem}, 4'd1);
      chk("t5_hold_busy", {3'b0, busy}, 4'd1);
    end
    @(posedge clk);
    #1;
    mem_busy    = 1'b0;
    issue_ready = 1'b1;
    drain("t5");

    // 6: asynchronous reset in the middle of an offer discards the bundle
    issue_ready = 1'b0;
    send({LD, ST, LD, ALU}, 1'b1);
    wait_valid("t6_valid");
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("t6_async");
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_bready_release", {3'b0, bundle_ready}, 4'd1);
    issue_ready = 1'b1;
    send({ST, ALU, ALU, LD}, 1'b1);
    drain("t6");

    // Random bundles with random back-pressure
    sent = 0;
    cyc  = 0;
    while ((sent < 40 || exp_q.size() != 0) && cyc < 4000) begin
      @(negedge clk);
      if (bundle_ready && sent < 40 && $urandom_range(0, 3) != 0) begin
        for (int i = 0; i < 4; i++) begin
          case ($urandom_range(0, 3))
            0:       rop = LD;
            1:       rop = ST;
            default: rop = 4'($urandom_range(0, 15));
          endcase
          rops[i*4 +: 4] = rop;
        end
        model_push(rops);
        bundle_valid = 1'b1;
        bundle_op    = rops;
        sent++;
      end
      @(posedge clk);
      #1;
      bundle_valid = 1'b0;
      issue_ready  = 1'($urandom_range(0, 1));
      cyc++;
    end
    if (sent < 40 || exp_q.size() != 0) fail_timeout("random_phase");
    issue_ready = 1'b1;
    drain("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
